sccb_init_seq: RTL and testbench

- Upstream feeder for the SCCB write controller: walks a camera register table and issues one SCCB write per entry over a valid/done handshake.
- Supports power-up wait, in-table millisecond delays, an end marker, and retry-on-NACK.
- Replaces software-driven WR_DATA/WR_FLAG pokes for boot-time sensor init; the PS only pulses start and reads status.

---
 rtl/sccb_init_seq.sv | 171 +++++++++++++++++
 tb/tb_sccb_init_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_seq.sv
// Boot-time camera init sequencer: walks a register table in external ROM and
// issues one SCCB write per entry, with power-up wait, table delays and NACK retry.
module sccb_init_seq #(
    parameter logic [7:0]  DEV_ID       = 8'h42,
    parameter int unsigned TABLE_DEPTH  = 256,
    parameter int unsigned TICKS_PER_MS = 100000,
    parameter int unsigned POWERUP_MS   = 20,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                           axi_clk,
    input  logic                           axi_rst,
    input  logic                           start,
    output logic [$clog2(TABLE_DEPTH)-1:0] table_addr,
    input  logic [15:0]                    table_data,
    output logic                           wr_valid,
    output logic [31:0]                    wr_data,
    input  logic                           wr_done,
    input  logic                           wr_nack,
    output logic                           busy,
    output logic                           done,
    output logic [7:0]                     err_cnt,
    output logic [15:0]                    wr_count
);

    localparam int unsigned AW        = $clog2(TABLE_DEPTH);
    localparam int unsigned PWR_TICKS = POWERUP_MS * TICKS_PER_MS;
    localparam int unsigned DLY_TICKS = 255 * TICKS_PER_MS;
    localparam int unsigned CNT_MAX   = (PWR_TICKS > DLY_TICKS) ? PWR_TICKS : DLY_TICKS;
    localparam int unsigned CW        = $clog2(CNT_MAX + 1);
    localparam int unsigned RW        = $clog2(MAX_RETRY + 2);

    typedef enum logic [3:0] {
        IDLE, PWRUP, FETCH, DECODE, ISSUE, WAIT, RETRY, DLY, FIN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            wr_valid_q, wr_valid_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      err_q, err_d;
    logic [15:0]     wcnt_q, wcnt_d;
    logic            advance;

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            retry_q    <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wcnt_q     <= wcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        wcnt_d    = wcnt_q;
        advance   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = '0;
                    wcnt_d  = '0;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(PWR_TICKS);
                    state_d = PWRUP;
                end
            end
            PWRUP: begin
                if (cnt_q <= CW'(1)) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (table_data == 16'hFFFF) begin
                    state_d = FIN;
                end else if (table_data[15:8] == 8'hFE) begin
                    if (table_data[7:0] == 8'h00) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d   = CW'(table_data[7:0]) * CW'(TICKS_PER_MS);
                        state_d = DLY;
                    end
                end else begin
                    wr_data_d = {8'h00, DEV_ID, table_data};
                    retry_d   = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (wr_done) begin
                    if (!wr_nack) begin
                        wcnt_d  = wcnt_q + 16'd1;
                        advance = 1'b1;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = RETRY;
                    end else begin
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                        advance = 1'b1;
                    end
                end
            end
            // one idle cycle so the controller sees a fresh wr_valid edge
            RETRY: state_d = ISSUE;
            DLY: begin
                if (cnt_q <= CW'(1)) advance = 1'b1;
                else cnt_d = cnt_q - CW'(1);
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (idx_q == AW'(TABLE_DEPTH - 1)) begin
                state_d = FIN;
            end else begin
                idx_d   = idx_q + AW'(1);
                state_d = FETCH;
            end
        end

        wr_valid_d = (state_d == ISSUE) || (state_d == WAIT);
        if (state_d == FIN) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    assign table_addr = idx_q;
    assign wr_valid   = wr_valid_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_cnt    = err_q;
    assign wr_count   = wcnt_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Self-checking bench for sccb_init_seq: per-run timeline model derived from the
// table contents, a controller model with fixed done latency, and literal pins.
module tb_sccb_init_seq;

    localparam int T        = 4;
    localparam int P        = 2;
    localparam int DEPTH    = 4;
    localparam int MR       = 3;
    localparam int DONE_LAT = 10;

    logic        axi_clk = 1'b0;
    logic        axi_rst = 1'b1;
    logic        start   = 1'b0;
    logic [1:0]  table_addr;
    logic [15:0] table_data;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_done = 1'b0;
    logic        wr_nack = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  err_cnt;
    logic [15:0] wr_count;

    sccb_init_seq #(
        .DEV_ID(8'h42), .TABLE_DEPTH(DEPTH), .TICKS_PER_MS(T),
        .POWERUP_MS(P), .MAX_RETRY(MR)
    ) dut (
        .axi_clk(axi_clk), .axi_rst(axi_rst), .start(start),
        .table_addr(table_addr), .table_data(table_data),
        .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_done(wr_done), .wr_nack(wr_nack),
        .busy(busy), .done(done), .err_cnt(err_cnt), .wr_count(wr_count)
    );

    always #5 axi_clk = ~axi_clk;

    logic [15:0] rom [0:DEPTH-1];
    always @(posedge axi_clk) table_data <= rom[table_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // expected timeline, in cycles relative to the start cycle
    int          exp_rise [0:31];
    logic [31:0] exp_data [0:31];
    int          ent_fetch [0:DEPTH-1];
    int          n_att, n_ent, exp_done_rel, exp_wcnt, exp_ecnt;
    int          nack_idx = -1;

    task automatic build_model(input int nack_entry);
        int t;
        logic [15:0] e;
        n_att = 0; n_ent = 0; exp_wcnt = 0; exp_ecnt = 0;
        t = 1 + P * T;
        for (int i = 0; i < DEPTH; i++) begin
            ent_fetch[i] = t;
            n_ent = i + 1;
            e = rom[i];
            t += 2;
            if (e == 16'hFFFF) break;
            if (e[15:8] == 8'hFE) begin
                t += int'(e[7:0]) * T;
            end else begin
                for (int a = 0; a <= ((i == nack_entry) ? MR : 0); a++) begin
                    exp_rise[n_att] = t;
                    exp_data[n_att] = {8'h00, 8'h42, e};
                    n_att++;
                    t += DONE_LAT + 1;
                    if (i == nack_entry && a < MR) t += 1;
                end
                if (i == nack_entry) exp_ecnt++;
                else exp_wcnt++;
            end
        end
        exp_done_rel = t;
    endtask

    // SCCB controller: done pulse DONE_LAT cycles after each wr_valid rise
    bit ctl_active = 1'b0;
    int ctl_cnt = 0;
    always @(negedge axi_clk) begin
        if (axi_rst) begin
            ctl_active = 1'b0;
            wr_done    = 1'b0;
        end else if (wr_done) begin
            wr_done = 1'b0;
        end else begin
            if (wr_valid && !ctl_active) begin
                ctl_active = 1'b1;
                ctl_cnt    = 0;
            end
            if (ctl_active) begin
                if (ctl_cnt == DONE_LAT) begin
                    wr_done    = 1'b1;
                    wr_nack    = (int'(table_addr) == nack_idx);
                    ctl_active = 1'b0;
                end else begin
                    ctl_cnt++;
                end
            end
        end
    end

    int          cyc = 0;
    int          run_s = 0;
    bit          run_active = 1'b0;
    int          rel, ea;
    logic        ev, prev_valid = 1'b0;
    logic [31:0] ed;
    int          first_rise, obs_done, n_rise, max_addr;
    logic [31:0] first_data;

    always @(posedge axi_clk) begin
        #1;
        cyc = cyc + 1;
        if (run_active && !axi_rst) begin
            rel = cyc - run_s;
            ev = 1'b0;
            ed = '0;
            for (int k = 0; k < n_att; k++)
                if (rel >= exp_rise[k] && rel <= exp_rise[k] + DONE_LAT) begin
                    ev = 1'b1;
                    ed = exp_data[k];
                end
            check("wr_valid", 32'(wr_valid), 32'(ev));
            if (ev) check("wr_data", wr_data, ed);
            check("busy", 32'(busy), 32'(rel < exp_done_rel));
            check("done", 32'(done), 32'(rel >= exp_done_rel));
            if (rel >= 1 + P * T) begin
                ea = 0;
                for (int k = 0; k < n_ent; k++) if (ent_fetch[k] <= rel) ea = k;
                check("table_addr", 32'(table_addr), 32'(ea));
            end
            if (rel == 1) begin
                check("wr_count_clr", 32'(wr_count), 32'd0);
                check("err_cnt_clr", 32'(err_cnt), 32'd0);
            end else if (rel >= exp_done_rel) begin
                check("wr_count", 32'(wr_count), 32'(exp_wcnt));
                check("err_cnt", 32'(err_cnt), 32'(exp_ecnt));
            end
            if (wr_valid && !prev_valid) n_rise++;
            if (wr_valid && first_rise < 0) begin
                first_rise = rel;
                first_data = wr_data;
            end
            if (done && obs_done < 0) obs_done = rel;
            if (int'(table_addr) > max_addr) max_addr = int'(table_addr);
        end
        prev_valid = wr_valid;
    end

    task automatic run_table(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d, input int nk);
        @(negedge axi_clk);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
        nack_idx = nk;
        build_model(nk);
        first_rise = -1; obs_done = -1; n_rise = 0; max_addr = 0;
        start = 1'b1;
        run_s = cyc;
        run_active = 1'b1;
        @(negedge axi_clk);
        start = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        while (cyc - run_s < r) @(negedge axi_clk);
    endtask

    task automatic stray_start(input int r);
        wait_rel(r);
        start = 1'b1;
        @(negedge axi_clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge axi_clk);
            if (done && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = 16'h0000;
        repeat (3) @(negedge axi_clk);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_table_addr", 32'(table_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        axi_rst = 1'b0;
        repeat (2) @(negedge axi_clk);

        // two writes then end marker, with an ignored start mid-run
        run_table(16'h1280, 16'h1100, 16'hFFFF, 16'h0000, -1);
        stray_start(15);
        wait_done();
        check("t1_first_rise", 32'(first_rise), 32'd11);
        check("t1_first_data", first_data, 32'h00421280);
        check("t1_done_rel", 32'(obs_done), 32'd37);
        check("t1_n_rise", 32'(n_rise), 32'd2);
        check("t1_wr_count", 32'(wr_count), 32'd2);
        check("t1_err_cnt", 32'(err_cnt), 32'd0);

        // 3 ms delay entry ahead of a single write
        run_table(16'hFE03, 16'h3A04, 16'hFFFF, 16'h0000, -1);
        wait_done();
        check("t2_first_rise", 32'(first_rise), 32'd25);
        check("t2_first_data", first_data, 32'h00423A04);
        check("t2_n_rise", 32'(n_rise), 32'd1);
        check("t2_done_rel", 32'(obs_done), 32'd38);

        // entry 0 NACKed on every attempt, stray start during retries
        run_table(16'h1280, 16'h1100, 16'hFFFF, 16'h0000, 0);
        stray_start(40);
        wait_done();
        check("t3_n_rise", 32'(n_rise), 32'd5);
        check("t3_err_cnt", 32'(err_cnt), 32'd1);
        check("t3_wr_count", 32'(wr_count), 32'd1);
        check("t3_done_rel", 32'(obs_done), 32'd73);

        // rerun after errors: counters and done cleared by start
        run_table(16'h1280, 16'h1100, 16'hFFFF, 16'h0000, -1);
        wait_done();
        check("t5_done_rel", 32'(obs_done), 32'd37);
        check("t5_err_cnt", 32'(err_cnt), 32'd0);

        // no end marker: table exhausted after DEPTH writes
        run_table(16'h0102, 16'h0304, 16'h0506, 16'h0708, -1);
        wait_done();
        check("t4_n_rise", 32'(n_rise), 32'd4);
        check("t4_done_rel", 32'(obs_done), 32'd61);
        check("t4_wr_count", 32'(wr_count), 32'd4);
        check("t4_max_addr", 32'(max_addr), 32'd3);

        // asynchronous reset while waiting on the controller
        run_table(16'h1280, 16'h1100, 16'hFFFF, 16'h0000, -1);
        wait_rel(15);
        check("t6_in_wait", 32'(wr_valid), 32'd1);
        run_active = 1'b0;
        axi_rst = 1'b1;
        #1;
        check("t6_rst_wr_valid", 32'(wr_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge axi_clk);
        axi_rst = 1'b0;
        run_table(16'h1280, 16'h1100, 16'hFFFF, 16'h0000, -1);
        wait_done();
        check("t6_first_rise", 32'(first_rise), 32'd11);
        check("t6_done_rel", 32'(obs_done), 32'd37);
        check("t6_wr_count", 32'(wr_count), 32'd2);

        repeat (3) @(negedge axi_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
